// File: rtl/video_coord_source.sv
// rtl/video_coord_source.sv - packetised pixel stream to (x,y)-tagged pixels with 2-entry skid buffer
// Optional CTRL_PKT_FILTER_EN: sop beat is a control header; non-zero types are dropped to eop.
module video_coord_source #(
    parameter int IMAGE_W = 640,
    parameter int IMAGE_H = 480,
    parameter int CW      = 11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [23:0]   in_data,
    input  logic          in_valid,
    input  logic          in_sop,
    input  logic          in_eop,
    output logic          in_ready,
    output logic [7:0]    out_r,
    output logic [7:0]    out_g,
    output logic [7:0]    out_b,
    output logic [CW-1:0] out_x,
    output logic [CW-1:0] out_y,
    output logic          out_sof,
    output logic          out_eof,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [15:0]   frame_cnt,
    output logic          frame_err
);

    localparam int WW = 24 + 2*CW + 2;
    localparam logic [CW-1:0] X_LAST = CW'(IMAGE_W - 1);
    localparam logic [CW-1:0] Y_LAST = CW'(IMAGE_H - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_OVERRUN
`ifdef CTRL_PKT_FILTER_EN
        , S_DROP
`endif
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   x_q, x_d, y_q, y_d;
    logic            init_q;
    logic [WW-1:0]   out_q, out_d, skid_q, skid_d;
    logic            out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
    logic            err_q, err_d;
    logic [15:0]     cnt_q, cnt_d;

    logic            acc, pop, emit, is_last;
    logic [CW-1:0]   cx, cy;
    logic [WW-1:0]   push_word;

    assign in_ready = init_q && !skid_valid_q;
    assign acc      = in_valid && in_ready;
    assign pop      = out_valid_q && out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            x_q          <= '0;
            y_q          <= '0;
            init_q       <= 1'b0;
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
            err_q        <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            init_q       <= 1'b1;
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
            err_q        <= err_d;
            cnt_q        <= cnt_d;
        end
    end

    // cx/cy is the coordinate the accepted beat is emitted at; a sop restarts it at (0,0).
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        cx      = x_q;
        cy      = y_q;
        emit    = 1'b0;
        err_d   = 1'b0;
        is_last = 1'b0;
        if (acc) begin
            case (state_q)
                S_IDLE, S_ACTIVE: begin
                    if (in_sop) begin
                        err_d = (state_q == S_ACTIVE);
`ifdef CTRL_PKT_FILTER_EN
                        x_d = '0;
                        y_d = '0;
                        if (in_eop)
                            state_d = S_IDLE;
                        else if (in_data[3:0] == 4'd0)
                            state_d = S_ACTIVE;
                        else
                            state_d = S_DROP;
`else
                        cx   = '0;
                        cy   = '0;
                        emit = 1'b1;
`endif
                    end else if (state_q == S_ACTIVE) begin
                        emit = 1'b1;
                    end
                end
                S_OVERRUN: if (in_eop) state_d = S_IDLE;
`ifdef CTRL_PKT_FILTER_EN
                S_DROP:    if (in_eop) state_d = S_IDLE;
`endif
                default:   state_d = S_IDLE;
            endcase
            if (emit) begin
                is_last = (cx == X_LAST) && (cy == Y_LAST);
                if (in_eop) begin
                    state_d = S_IDLE;
                    if (!is_last) err_d = 1'b1;
                end else if (is_last) begin
                    state_d = S_OVERRUN;
                    err_d   = 1'b1;
                end else begin
                    state_d = S_ACTIVE;
                    if (cx == X_LAST) begin
                        x_d = '0;
                        y_d = cy + CW'(1);
                    end else begin
                        x_d = cx + CW'(1);
                        y_d = cy;
                    end
                end
            end
        end
    end

    assign push_word = {in_data, cx, cy, (cx == '0) && (cy == '0), is_last};

    // Skid register only fills while the output register is stalled; it drains first.
    always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        cnt_d        = cnt_q + ((pop && out_q[0]) ? 16'd1 : 16'd0);
        if (!out_valid_q || out_ready) begin
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = emit;
                if (emit) out_d = push_word;
            end
        end else if (emit) begin
            skid_d       = push_word;
            skid_valid_d = 1'b1;
        end
    end

    assign out_r     = out_q[WW-1 -: 8];
    assign out_g     = out_q[WW-9 -: 8];
    assign out_b     = out_q[WW-17 -: 8];
    assign out_x     = out_q[2*CW+1 -: CW];
    assign out_y     = out_q[CW+1 -: CW];
    assign out_sof   = out_q[1];
    assign out_eof   = out_q[0];
    assign out_valid = out_valid_q;
    assign frame_cnt = cnt_q;
    assign frame_err = err_q;

endmodule

// File: tb/tb_video_coord_source.sv
// tb/tb_video_coord_source.sv - self-checking bench for video_coord_source (reduced 40x30 raster)
module tb_video_coord_source;

    localparam int W = 40;
    localparam int H = 30;
    localparam int N = W * H;
    localparam int CW = 11;
    localparam int M_IDLE = 0, M_ACT = 1, M_OVR = 2, M_DROP = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [23:0]   in_data;
    logic          in_valid, in_sop, in_eop, in_ready;
    logic [7:0]    out_r, out_g, out_b;
    logic [CW-1:0] out_x, out_y;
    logic          out_sof, out_eof, out_valid, out_ready;
    logic [15:0]   frame_cnt;
    logic          frame_err;

    video_coord_source #(.IMAGE_W(W), .IMAGE_H(H), .CW(CW)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop), .in_ready(in_ready),
        .out_r(out_r), .out_g(out_g), .out_b(out_b), .out_x(out_x), .out_y(out_y),
        .out_sof(out_sof), .out_eof(out_eof), .out_valid(out_valid), .out_ready(out_ready),
        .frame_cnt(frame_cnt), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    typedef struct { logic [23:0] data; logic sop; logic eop; } beat_t;
    typedef struct { logic [23:0] data; int x; int y; logic sof; logic eof; } pix_t;
    typedef struct { logic [23:0] d; logic sop; logic eop; logic ev; int ex; int ey; logic eerr; } vec_t;

    beat_t stim_q[$];
    pix_t  exp_q[$];
    int    vectors = 0, fails = 0;
    int    m_mode, m_n, exp_frames, exp_errs, err_seen;
    int    accepted = 0, drv_cycles, rmode = 0, stall_at = -1;
    logic  mon_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: pixel index n within the frame gives x = n mod W, y = n / W.
    function automatic void model_pixel(beat_t b);
        pix_t p;
        p.data = b.data; p.x = m_n % W; p.y = m_n / W;
        p.sof = (m_n == 0); p.eof = (m_n == N - 1);
        exp_q.push_back(p);
        if (p.eof) exp_frames++;
        if (b.eop) begin
            m_mode = M_IDLE;
            if (m_n != N - 1) exp_errs++;
        end else if (m_n == N - 1) begin
            m_mode = M_OVR;
            exp_errs++;
        end else begin
            m_n++;
            m_mode = M_ACT;
        end
    endfunction

    function automatic void model_beat(beat_t b);
        if ((m_mode == M_IDLE || m_mode == M_ACT) && b.sop) begin
            if (m_mode == M_ACT) exp_errs++;
            m_n = 0;
`ifdef CTRL_PKT_FILTER_EN
            if (b.eop) m_mode = M_IDLE;
            else if (b.data[3:0] == 4'd0) m_mode = M_ACT;
            else m_mode = M_DROP;
`else
            model_pixel(b);
`endif
        end else if (m_mode == M_ACT) begin
            model_pixel(b);
        end else if (b.eop) begin
            m_mode = M_IDLE;
        end
    endfunction

    always @(posedge clk) begin : ready_drv
        int stall_left;
        int done_at;
        #1;
        if (stall_at >= 0 && accepted == stall_at && done_at != stall_at) begin
            stall_left = 5;
            done_at = stall_at;
        end
        if (stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
        end else begin
            case (rmode)
                0: out_ready = 1'b1;
                1: out_ready = !out_ready;
                default: out_ready = 1'($urandom_range(1));
            endcase
        end
    end

    logic [48:0] snap, cur;
    logic        prev_stall;
    int          up_cyc;
    pix_t        mp;
    beat_t       mb;
    always @(negedge clk) begin
        cur = {out_valid, out_r, out_g, out_b, out_x, out_y, out_sof, out_eof};
        if (!rst) begin
            m_mode = M_IDLE; m_n = 0; exp_q.delete();
            exp_frames = 0; exp_errs = 0; err_seen = 0;
            up_cyc = 0; prev_stall = 1'b0;
        end else begin
            up_cyc++;
            if (mon_en) begin
                if (prev_stall) check("stall_hold", 64'(cur), 64'(snap));
                if (up_cyc >= 2 && !in_ready) check("in_ready_low_without_full_skid", 64'(prev_stall), 64'd1);
                if (frame_err) err_seen++;
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_output", 64'(cur), 64'd0);
                    end else begin
                        mp = exp_q.pop_front();
                        check("pix", 64'(cur[47:0]),
                              64'({mp.data, CW'(mp.x), CW'(mp.y), mp.sof, mp.eof}));
                    end
                end
                if (in_valid && in_ready) begin
                    mb.data = in_data; mb.sop = in_sop; mb.eop = in_eop;
                    model_beat(mb);
                end
            end
            prev_stall = out_valid && !out_ready;
        end
        snap = cur;
    end

    task automatic build_frame(input int npix, input bit eop_last);
        beat_t b;
`ifdef CTRL_PKT_FILTER_EN
        b.data = 24'h0; b.sop = 1'b1; b.eop = 1'b0;
        stim_q.push_back(b);
`endif
        for (int i = 0; i < npix; i++) begin
            b.data = 24'(i);
`ifdef CTRL_PKT_FILTER_EN
            b.sop = 1'b0;
`else
            b.sop = (i == 0);
`endif
            b.eop = eop_last && (i == npix - 1);
            stim_q.push_back(b);
        end
    endtask

    task automatic drive_all(input int gap_pct);
        int blocked = 0;
        drv_cycles = 0;
        while (stim_q.size() > 0) begin
            in_data  = stim_q[0].data;
            in_sop   = stim_q[0].sop;
            in_eop   = stim_q[0].eop;
            in_valid = ($urandom_range(99) >= gap_pct);
            @(negedge clk);
            drv_cycles++;
            if (in_valid && in_ready) begin
                void'(stim_q.pop_front());
                accepted++;
                blocked = 0;
            end else if (in_valid) begin
                blocked++;
                if (blocked > 500) begin
                    check("in_ready_timeout", 64'(blocked), 64'd0);
                    stim_q.delete();
                end
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_sop = 1'b0;
        in_eop = 1'b0;
    endtask

    task automatic end_scenario(input string name);
        int t = 0;
        while (exp_q.size() != 0 && t < 5000) begin
            @(posedge clk);
            t++;
        end
        repeat (3) @(posedge clk);
        #1;
        check({name, "_drain"}, 64'(exp_q.size()), 64'd0);
        check({name, "_frame_cnt"}, 64'(frame_cnt), 64'(16'(exp_frames)));
        check({name, "_frame_err_pulses"}, 64'(err_seen), 64'(exp_errs));
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        vec_t tbl[10];
        beat_t b;
        int nb;
        rst = 1'b0; in_valid = 1'b0; in_data = '0; in_sop = 1'b0; in_eop = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 64'({in_ready, out_valid, frame_err, frame_cnt, out_x, out_y, out_sof, out_eof}), 64'd0);
        check("reset_pixel", 64'({out_r, out_g, out_b}), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        check("in_ready_before_first_edge", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        check("in_ready_after_first_edge", 64'(in_ready), 64'd1);

`ifndef CTRL_PKT_FILTER_EN
        tbl[0] = '{24'h000001, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0};
        tbl[1] = '{24'h000002, 1'b1, 1'b0, 1'b1, 0, 0, 1'b0};
        tbl[2] = '{24'h000003, 1'b0, 1'b0, 1'b1, 1, 0, 1'b0};
        tbl[3] = '{24'h000004, 1'b0, 1'b0, 1'b1, 2, 0, 1'b0};
        tbl[4] = '{24'hABCDEF, 1'b1, 1'b0, 1'b1, 0, 0, 1'b1};
        tbl[5] = '{24'h000006, 1'b0, 1'b0, 1'b1, 1, 0, 1'b0};
        tbl[6] = '{24'h000007, 1'b0, 1'b1, 1'b1, 2, 0, 1'b1};
        tbl[7] = '{24'h000008, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0};
        tbl[8] = '{24'h123456, 1'b1, 1'b1, 1'b1, 0, 0, 1'b1};
        tbl[9] = '{24'h00000A, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0};
        for (int i = 0; i < 10; i++) begin
            in_data = tbl[i].d; in_sop = tbl[i].sop; in_eop = tbl[i].eop; in_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            check("tbl_valid", 64'(out_valid), 64'(tbl[i].ev));
            if (tbl[i].ev)
                check("tbl_pix", 64'({out_r, out_g, out_b, out_x, out_y}),
                      64'({tbl[i].d, CW'(tbl[i].ex), CW'(tbl[i].ey)}));
            check("tbl_err", 64'(frame_err), 64'(tbl[i].eerr));
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
`endif
        mon_en = 1'b1;

        rmode = 0;
        build_frame(N, 1'b1);
        nb = stim_q.size();
        drive_all(0);
        check("full_rate_cycles", 64'(drv_cycles), 64'(nb));
        end_scenario("full");

        rmode = 1;
        stall_at = accepted + 300;
        build_frame(N, 1'b1);
        drive_all(0);
        end_scenario("toggle");

        rmode = 0;
        build_frame(100, 1'b1);
        build_frame(N, 1'b1);
        drive_all(0);
        end_scenario("short");

        build_frame(N + 3, 1'b1);
        drive_all(0);
        end_scenario("overrun");

        rmode = 2;
        for (int k = 0; k < 3; k++) begin
            build_frame($urandom_range(N + 5, 50), 1'($urandom_range(1)));
            for (int i = 0; i < 200; i++) begin
                b.data = 24'($urandom);
                b.sop = ($urandom_range(149) == 0);
                b.eop = ($urandom_range(99) == 0);
                stim_q.push_back(b);
            end
        end
        drive_all(20);
        end_scenario("random");

        rmode = 0;
        build_frame(500, 1'b0);
        drive_all(0);
        rst = 1'b0;
        #1;
        check("midframe_reset_clear", 64'({in_ready, out_valid, frame_err, frame_cnt, out_x, out_y, out_sof, out_eof}), 64'd0);
        check("midframe_reset_pixel", 64'({out_r, out_g, out_b}), 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("in_ready_after_reset", 64'(in_ready), 64'd1);
        for (int i = 0; i < 20; i++) begin
            b.data = 24'($urandom); b.sop = 1'b0; b.eop = (i == 7);
            stim_q.push_back(b);
        end
        build_frame(N, 1'b1);
        drive_all(10);
        end_scenario("after_reset");

`ifdef CTRL_PKT_FILTER_EN
        for (int i = 0; i < 10; i++) begin
            b.data = (i == 0) ? 24'h00000F : 24'(i); b.sop = (i == 0); b.eop = (i == 9);
            stim_q.push_back(b);
        end
        build_frame(N, 1'b1);
        drive_all(0);
        end_scenario("ctrl");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

// File: doc/video_coord_source.md
Name: video_coord_source

Overview:
- Producer end of the per-pixel RGB + (x,y) interface consumed by the temporal filter and downstream vision stages.
- Accepts the camera/VIP packetised pixel stream (valid/ready, sop/eop).
- Attaches raster coordinates to each pixel and emits it with a valid/ready handshake.
- Detects malformed frames, resynchronises on them and counts completed frames.

Parameters:
- IMAGE_W, 640, active pixels per line.
- IMAGE_H, 480, active lines per frame.
- CW, 11, coordinate width for out_x and out_y (must hold IMAGE_W-1 and IMAGE_H-1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_data  in  24  pixel: [23:16]=R, [15:8]=G, [7:0]=B.
- in_valid  in  1  in_data/in_sop/in_eop valid.
- in_sop  in  1  first beat of packet.
- in_eop  in  1  last beat of packet.
- in_ready  out  1  block can accept a beat.
- out_r, out_g, out_b  out  8 each  pixel channels.
- out_x  out  CW  column, 0..IMAGE_W-1.
- out_y  out  CW  line, 0..IMAGE_H-1.
- out_sof  out  1  pixel is (0,0).
- out_eof  out  1  pixel is (IMAGE_W-1, IMAGE_H-1).
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- frame_cnt  out  16  completed frames, wraps at 65535->0.
- frame_err  out  1  one-cycle pulse per malformed-frame event.

Behaviour:
- Clock and reset (decided): one clock, clk; reset rst is asynchronous and active-low.
- Reset values: all outputs 0, including in_ready, out_valid and frame_cnt. in_ready rises on the first clk after rst deasserts. Reset mid-frame discards all held data, and the block restarts in IDLE.
- Handshake:
  - An input beat transfers on in_valid && in_ready.
  - An output beat transfers on out_valid && out_ready.
  - While out_valid=1 && out_ready=0, all out_* stay stable.
- Buffering:
  - 2-entry skid buffer (output register + skid register).
  - in_ready = skid register empty.
  - Full throughput: one pixel per cycle with out_ready held high.
  - Latency: input beat to out_valid is 1 cycle.
- State machine (pixel_cnt is 0..IMAGE_W*IMAGE_H):
  - IDLE: beats without sop are accepted and dropped, with no output. A sop beat enters ACTIVE; without the optional feature, that beat is emitted as pixel (0,0).
  - ACTIVE:
    - Each accepted beat is emitted at the current (x,y).
    - x increments; at x=IMAGE_W-1, x wraps to 0 and y increments.
    - The beat at (IMAGE_W-1, IMAGE_H-1) has out_eof=1 and increments frame_cnt when it is accepted at the output.
    - If that beat also has eop: go to IDLE.
    - If that beat has no eop: go to OVERRUN.
  - OVERRUN: beats are accepted and dropped; frame_err pulses once on entry; eop returns the block to IDLE.
  - DROP: see Optional Feature.
- Boundary cases:
  - eop before pixel_cnt reaches IMAGE_W*IMAGE_H (short frame): that beat is emitted, frame_err pulses, frame_cnt does not increment, and the block goes to IDLE.
  - sop seen in ACTIVE: frame_err pulses, coordinates restart at (0,0), and the sop beat is emitted as the new (0,0) pixel (unless it is a control header under the optional feature).
  - sop and eop on the same beat in IDLE: treated as a 1-pixel short frame; it is emitted as (0,0) and frame_err pulses.
- Coordinate arithmetic: unsigned, width CW; x and y never exceed IMAGE_W-1 and IMAGE_H-1.

Optional Feature:
- Macro: CTRL_PKT_FILTER_EN.
- Defined:
  - The sop beat is a packet header with type = in_data[3:0]; it is never emitted.
  - Type 0 goes to ACTIVE with (x,y)=(0,0) for the next beat.
  - Any other type goes to DROP: all beats are dropped without error until eop, then the block returns to IDLE.
  - A header with eop goes to IDLE.
- Undefined: no header interpretation. The DROP state is not built, and the sop beat is pixel (0,0).

Test Plan:
- 640x480 frame, out_ready=1, pixel n data = n mod 2^24 -> 307200 outputs; pixel 641 has x=1, y=1; last pixel x=639, y=479 with out_eof=1; frame_cnt=1; frame_err never asserted.
- Same frame with out_ready toggling 1/0 every cycle, plus a 5-cycle stall -> no loss or duplication; out_* stable while stalled; in_ready=0 only when the skid buffer is full.
- eop on beat 1000 -> 1000 outputs, last at x=359, y=1; frame_err 1-cycle pulse; frame_cnt unchanged; the next sop frame starts at (0,0).
- 307203 beats with eop on the last -> 307200 outputs, one frame_err pulse, frame_cnt+1.
- rst low for 1 cycle mid-frame at pixel 5000 -> all outputs 0 immediately; in_ready=1 the next cycle; non-sop beats dropped until the next sop.
- CTRL_PKT_FILTER_EN defined: header type 0xF packet of 10 beats, then a type-0 frame -> no output for the control packet, no frame_err; first pixel after the type-0 header is (0,0).
